// File: rtl/mem_access_stage.sv
`default_nettype none
// ============================================================================
//  Module      : mem_access_stage
//  Description : MEM pipeline stage. Runs a req/ack handshake with data
//                memory for loads/stores, stalls earlier stages while an
//                access is outstanding, and drives the MEM/WB register.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_access_stage #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        RegWrite_i,
    input  logic        MemtoReg_i,
    input  logic        MemRead_i,
    input  logic        MemWrite_i,
    input  logic [31:0] ALUout_i,
    input  logic [31:0] rs2_i,
    input  logic [4:0]  rd_i,
    output logic        stall_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i,
    output logic        RegWrite_o,
    output logic        MemtoReg_o,
    output logic [31:0] ReadData_o,
    output logic [31:0] ALUout_o,
    output logic [4:0]  rd_o,
    output logic        misalign_o,
    output logic        err_o
);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_REQ  = 2'd1;
    localparam logic [1:0] c_ST_DONE = 2'd2;

    // Counter only needs to reach TIMEOUT-1; width of 1 when the watchdog is off.
    localparam int             c_CW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_CW-1:0] c_CNT_LAST = c_CW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

    logic [1:0]      r_state;
    logic [1:0]      w_next_state;
    logic [c_CW-1:0] r_cnt;
    logic            r_req;
    logic            r_we;
    logic [31:0]     r_addr;
    logic [31:0]     r_wdata;
    logic [31:0]     r_rdata;
    logic            r_err;

    logic            r_regwrite;
    logic            r_memtoreg;
    logic [31:0]     r_readdata;
    logic [31:0]     r_aluout;
    logic [4:0]      r_rd;
    logic            r_misalign;

    logic            w_memacc;
    logic            w_misacc;
    logic            w_op;
    logic            w_timeout;
    logic            w_stall;

    assign w_memacc  = MemRead_i | MemWrite_i;
    assign w_misacc  = w_memacc & (ALUout_i[1:0] != 2'b00);
    assign w_op      = w_memacc & (ALUout_i[1:0] == 2'b00);
    assign w_timeout = (TIMEOUT > 0) && (r_cnt == c_CNT_LAST);
    assign w_stall   = ((r_state == c_ST_IDLE) & w_op) | (r_state == c_ST_REQ);

    // Next-state decode for the access handshake
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_ST_IDLE: if (w_op) w_next_state = c_ST_REQ;
            c_ST_REQ:  if (mem_ack_i || w_timeout) w_next_state = c_ST_DONE;
            c_ST_DONE: w_next_state = c_ST_IDLE;
            default:   w_next_state = c_ST_IDLE;
        endcase
    end

    // State register, memory request fields, watchdog and latched load data
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= c_ST_IDLE;
            r_cnt   <= '0;
            r_req   <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next_state;
            case (r_state)
                c_ST_IDLE: begin
                    r_cnt <= '0;
                    if (w_op) begin
                        r_req   <= 1'b1;
                        // A simultaneous read+write is executed as a store.
                        r_we    <= MemWrite_i;
                        r_addr  <= ALUout_i;
                        r_wdata <= rs2_i;
                    end
                end
                c_ST_REQ: begin
                    if (mem_ack_i) begin
                        r_rdata <= mem_rdata_i;
                        r_req   <= 1'b0;
                    end else if (w_timeout) begin
                        r_rdata <= '0;
                        r_req   <= 1'b0;
                        r_err   <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // MEM/WB register: bubble while stalled, otherwise advance from EX/MEM
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_regwrite <= 1'b0;
            r_memtoreg <= 1'b0;
            r_readdata <= '0;
            r_aluout   <= '0;
            r_rd       <= '0;
            r_misalign <= 1'b0;
        end else begin
            r_misalign <= w_misacc & ~w_stall;
            if (w_stall) begin
                r_regwrite <= 1'b0;
                r_memtoreg <= 1'b0;
            end else begin
                // No write-back for a dropped misaligned load or a read+write op.
                r_regwrite <= RegWrite_i & ~(MemRead_i & MemWrite_i) & ~(w_misacc & MemRead_i);
                r_memtoreg <= MemtoReg_i;
                r_aluout   <= ALUout_i;
                r_rd       <= rd_i;
                if (r_state == c_ST_DONE) r_readdata <= r_rdata;
            end
        end
    end

    assign stall_o     = w_stall;
    assign mem_req_o   = r_req;
    assign mem_we_o    = r_we;
    assign mem_addr_o  = r_addr;
    assign mem_wdata_o = r_wdata;
    assign RegWrite_o  = r_regwrite;
    assign MemtoReg_o  = r_memtoreg;
    assign ReadData_o  = r_readdata;
    assign ALUout_o    = r_aluout;
    assign rd_o        = r_rd;
    assign misalign_o  = r_misalign;
    assign err_o       = r_err;

endmodule
`default_nettype wire
